// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// States of the receiver FSM plus byte/word geometry.
package selen_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_BITS      = 8;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Program-memory write port of the boot loader.
// valid/ready: a write is accepted when mem_we && mem_ready.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 5
);

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );

endinterface

// File: rtl/uart_boot_loader_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, bit timer and RX FSM.
// Emits one-cycle byte strobe or frame-error pulse per frame.
module uart_rx_core
  import selen_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_stb,
  output logic       frame_err_pulse
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);

  logic      s1, s2, s3;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic stb_d, ferr_d, tick;

  // s3 is the previous synchronized value, used for edge detect
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= uart_rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_q           <= '0;
      sh_q            <= '0;
      byte_stb        <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_q           <= bit_d;
      sh_q            <= sh_d;
      byte_stb        <= stb_d;
      frame_err_pulse <= ferr_d;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    stb_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s3 && !s2) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (tick) begin
          if (!s2) begin
            state_d = DATA;
            cnt_d   = FULL;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sh_d  = {s2, sh_q[7:1]};
          cnt_d = FULL;
          bit_d = bit_q + 3'd1;
          if (bit_q == LAST_BIT)
            state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (s2) begin
            stb_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (s2)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data = sh_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART program loader: packs bytes into words, writes RAM.
// BOOT_CHECKSUM_EN: trailing XOR byte gates boot_done.
module uart_boot_loader
  import selen_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_COUNT   = 32,
  parameter int ADDR_W       = 5
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic uart_rx,
  uart_boot_loader_if.master mem,
  output logic boot_done,
  output logic frame_err,
  output logic overrun_err,
  output logic csum_err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] ALL_WORDS =
    CNT_W'(WORD_COUNT);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(WORD_COUNT - 1);
  localparam logic [1:0] LAST_IDX =
    2'(BYTES_PER_WORD - 1);

  logic [7:0] rx_byte;
  logic       rx_stb, rx_ferr;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .uart_rx        (uart_rx),
    .byte_data      (rx_byte),
    .byte_stb       (rx_stb),
    .frame_err_pulse(rx_ferr)
  );

  logic [1:0]        idx_q;
  logic [23:0]       stage_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  words_q;
  logic done_q, ferr_q, ovr_q;
  logic accept, img_byte, word_end, last_acc;

  assign accept   = we_q & mem.mem_ready;
  assign img_byte = rx_stb & (words_q != ALL_WORDS);
  assign word_end = img_byte & (idx_q == LAST_IDX);
  assign last_acc = accept & (addr_q == LAST_ADDR);

  // words_q counts completed words, dropped ones included
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_q   <= '0;
      stage_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      words_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (rx_ferr)
        ferr_q <= 1'b1;
      if (img_byte) begin
        idx_q <= idx_q + 2'd1;
        unique case (idx_q)
          2'd0:    stage_q[7:0]   <= rx_byte;
          2'd1:    stage_q[15:8]  <= rx_byte;
          2'd2:    stage_q[23:16] <= rx_byte;
          default: ;
        endcase
      end
      if (accept) begin
        we_q <= 1'b0;
        if (addr_q != LAST_ADDR)
          addr_q <= addr_q + 1'b1;
      end
      if (word_end) begin
        words_q <= words_q + 1'b1;
        if (we_q && !mem.mem_ready) begin
          ovr_q <= 1'b1;
        end else begin
          we_q    <= 1'b1;
          addr_q  <= words_q[ADDR_W-1:0];
          wdata_q <= {rx_byte, stage_q};
        end
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       loaded_q, csum_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      xor_q    <= '0;
      loaded_q <= 1'b0;
      csum_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (img_byte)
        xor_q <= xor_q ^ rx_byte;
      if (last_acc)
        loaded_q <= 1'b1;
      // first good byte after the image is the checksum
      if (rx_stb && loaded_q && !done_q && !csum_q) begin
        if (rx_byte == xor_q)
          done_q <= 1'b1;
        else
          csum_q <= 1'b1;
      end
    end
  end

  assign csum_err = csum_q;
`else
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      done_q <= 1'b0;
    else if (last_acc)
      done_q <= 1'b1;
  end

  assign csum_err = 1'b0;
`endif

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign boot_done     = done_q;
  assign frame_err     = ferr_q;
  assign overrun_err   = ovr_q;

endmodule
